// File: rtl/cfg_frame_parser.sv
// ---------------------------------------------------------------------------
// cfg_frame_parser
//
// Parses byte-serial command frames (EB 90 CMD AH AL D3 D2 D1 D0 [CS]) and
// turns them into register-bus write/read strobes. A read frame produces a
// response frame (EB 90 02 AH AL D3 D2 D1 D0 [CS]) on the tx byte stream.
// Rejected frames (byte timeout, unknown command, bad checksum, read data
// timeout) are counted in a saturating error counter.
//
// Build option: define CFG_FRAME_CHECKSUM_EN to carry a trailing checksum byte
// (mod-256 sum of CMD..D0) on both command and response frames. Without it,
// frames are 9 bytes and no checksum logic is built.
//
// Parameters:
//   U_DLY        - legacy register-assignment delay in ns (not modelled here)
//   BYTE_TIMEOUT - max idle clk_sys cycles between two bytes of a frame
//   RD_TIMEOUT   - max cycles to wait for inter_cfg_rd_data_valid
//
// Ports:
//   clk_sys                 in   system clock, rising edge
//   rst_n                   in   asynchronous active-low reset
//   rx_data / rx_valid      in   received byte stream, no backpressure
//   inter_cfg_wr_en         out  one-cycle register write strobe
//   inter_cfg_rd_en         out  one-cycle register read strobe
//   inter_cfg_addr          out  register address (held between strobes)
//   inter_cfg_wr_data       out  register write data (held between strobes)
//   inter_cfg_rd_data       in   register read data
//   inter_cfg_rd_data_valid in   read data qualifier
//   tx_data / tx_valid      out  response byte stream
//   tx_ready                in   downstream accepts on tx_valid && tx_ready
//   frame_err_cnt           out  saturating count of rejected frames
// ---------------------------------------------------------------------------
module cfg_frame_parser #(
    parameter int          U_DLY        = 1,
    parameter logic [31:0] BYTE_TIMEOUT = 32'd1_000_000,
    parameter logic [7:0]  RD_TIMEOUT   = 8'd15
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        inter_cfg_wr_en,
    output logic        inter_cfg_rd_en,
    output logic [15:0] inter_cfg_addr,
    output logic [31:0] inter_cfg_wr_data,
    input  logic [31:0] inter_cfg_rd_data,
    input  logic        inter_cfg_rd_data_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] frame_err_cnt
);

    localparam logic [2:0] S_HDR0   = 3'd0;
    localparam logic [2:0] S_HDR1   = 3'd1;
    localparam logic [2:0] S_BODY   = 3'd2;
`ifdef CFG_FRAME_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd3;
`endif
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_RDWAIT = 3'd5;
    localparam logic [2:0] S_TX     = 3'd6;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

`ifdef CFG_FRAME_CHECKSUM_EN
    localparam logic [3:0] TX_LAST = 4'd9;
`else
    localparam logic [3:0] TX_LAST = 4'd8;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

`ifdef CFG_FRAME_CHECKSUM_EN
    // Mod-256 sum of the seven payload bytes CMD..D0
    function automatic logic [7:0] sum_bytes(input logic [55:0] f);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 7; i++) begin
            s = s + f[i*8 +: 8];
        end
        return s;
    endfunction
`endif

    function automatic logic [7:0] resp_byte(input logic [3:0]  idx,
                                             input logic [15:0] addr,
                                             input logic [31:0] data);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hEB;
            4'd1:    b = 8'h90;
            4'd2:    b = CMD_RD;
            4'd3:    b = addr[15:8];
            4'd4:    b = addr[7:0];
            4'd5:    b = data[31:24];
            4'd6:    b = data[23:16];
            4'd7:    b = data[15:8];
            4'd8:    b = data[7:0];
`ifdef CFG_FRAME_CHECKSUM_EN
            4'd9:    b = sum_bytes({CMD_RD, addr, data});
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [2:0]  state_r;
    logic [31:0] gap_cnt_r;
    logic [2:0]  body_cnt_r;
    logic [55:0] body_r;       // CMD AH AL D3 D2 D1 D0, CMD in the top byte
    logic [7:0]  rd_cnt_r;
    logic [31:0] rd_data_r;
    logic [3:0]  tx_idx_r;

    logic [55:0] frame_s;
    logic        frame_done_s;
    logic        timeout_s;
    logic        rd_expire_s;

    // The gap counter already holds BYTE_TIMEOUT idle cycles, so one more idle cycle exceeds it
    assign timeout_s   = !rx_valid && (gap_cnt_r >= BYTE_TIMEOUT);
    // Widened compare keeps RD_TIMEOUT = 0 from wrapping
    assign rd_expire_s = (({1'b0, rd_cnt_r} + 9'd1) >= {1'b0, RD_TIMEOUT});

    // Final-byte detection: the frame is complete and good on this clock edge
    always_comb begin
        frame_done_s = 1'b0;
`ifdef CFG_FRAME_CHECKSUM_EN
        frame_s = body_r;
        if ((state_r == S_CHK) && rx_valid && (rx_data == sum_bytes(body_r))) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
`else
        frame_s = {body_r[47:0], rx_data};
        if ((state_r == S_BODY) && rx_valid && (body_cnt_r == 3'd6)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
`endif
    end

    // Register-bus strobes; launched on the final byte so they are high in the EXEC cycle
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            inter_cfg_wr_en   <= 1'b0;
            inter_cfg_rd_en   <= 1'b0;
            inter_cfg_addr    <= 16'h0000;
            inter_cfg_wr_data <= 32'h0000_0000;
        end else begin
            inter_cfg_wr_en <= frame_done_s && (frame_s[55:48] == CMD_WR);
            inter_cfg_rd_en <= frame_done_s && (frame_s[55:48] == CMD_RD);
            if (frame_done_s && (frame_s[55:48] == CMD_WR)) begin
                inter_cfg_addr    <= frame_s[47:32];
                inter_cfg_wr_data <= frame_s[31:0];
            end else if (frame_done_s && (frame_s[55:48] == CMD_RD)) begin
                inter_cfg_addr    <= frame_s[47:32];
            end
        end
    end

    // Frame FSM, byte timeout, read wait, response transmitter and error counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_HDR0;
            gap_cnt_r     <= 32'd0;
            body_cnt_r    <= 3'd0;
            body_r        <= 56'd0;
            rd_cnt_r      <= 8'd0;
            rd_data_r     <= 32'h0000_0000;
            tx_idx_r      <= 4'd0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            frame_err_cnt <= 16'h0000;
        end else begin
            case (state_r)
                S_HDR0: begin
                    gap_cnt_r <= 32'd0;
                    if (rx_valid && (rx_data == 8'hEB)) begin
                        state_r <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (rx_valid) begin
                        gap_cnt_r <= 32'd0;
                        if (rx_data == 8'h90) begin
                            state_r    <= S_BODY;
                            body_cnt_r <= 3'd0;
                        end else if (rx_data != 8'hEB) begin
                            state_r <= S_HDR0;
                        end
                    end else if (timeout_s) begin
                        state_r       <= S_HDR0;
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 32'd1;
                    end
                end
                S_BODY: begin
                    if (rx_valid) begin
                        gap_cnt_r <= 32'd0;
                        body_r    <= {body_r[47:0], rx_data};
                        if (body_cnt_r == 3'd6) begin
`ifdef CFG_FRAME_CHECKSUM_EN
                            state_r <= S_CHK;
`else
                            state_r <= S_EXEC;
`endif
                        end else begin
                            body_cnt_r <= body_cnt_r + 3'd1;
                        end
                    end else if (timeout_s) begin
                        state_r       <= S_HDR0;
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 32'd1;
                    end
                end
`ifdef CFG_FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        gap_cnt_r <= 32'd0;
                        if (frame_done_s) begin
                            state_r <= S_EXEC;
                        end else begin
                            state_r       <= S_HDR0;
                            frame_err_cnt <= sat_inc(frame_err_cnt);
                        end
                    end else if (timeout_s) begin
                        state_r       <= S_HDR0;
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 32'd1;
                    end
                end
`endif
                S_EXEC: begin
                    // Strobe is already on the bus this cycle; only sequencing remains
                    if (body_r[55:48] == CMD_RD) begin
                        state_r  <= S_RDWAIT;
                        rd_cnt_r <= 8'd0;
                    end else if (body_r[55:48] == CMD_WR) begin
                        state_r <= S_HDR0;
                    end else begin
                        state_r       <= S_HDR0;
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                    end
                end
                S_RDWAIT: begin
                    if (inter_cfg_rd_data_valid || rd_expire_s) begin
                        rd_data_r <= inter_cfg_rd_data_valid ? inter_cfg_rd_data : 32'h0000_0000;
                        if (!inter_cfg_rd_data_valid) begin
                            frame_err_cnt <= sat_inc(frame_err_cnt);
                        end
                        state_r  <= S_TX;
                        tx_valid <= 1'b1;
                        tx_data  <= 8'hEB;
                        tx_idx_r <= 4'd0;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 8'd1;
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        if (tx_idx_r == TX_LAST) begin
                            tx_valid <= 1'b0;
                            state_r  <= S_HDR0;
                        end else begin
                            tx_idx_r <= tx_idx_r + 4'd1;
                            tx_data  <= resp_byte(tx_idx_r + 4'd1, inter_cfg_addr, rd_data_r);
                        end
                    end
                end
                default: begin
                    state_r  <= S_HDR0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_cfg_frame_parser
//
// Scoreboard bench: every frame sent pushes its expected write strobe, read
// strobe and response bytes into queues; a negedge monitor pops and compares
// whenever the DUT shows a strobe or a tx handshake. A simple register slave
// answers read strobes. Expected values come from the frame rules (sum of
// bytes, command meaning), not from the DUT.
// ---------------------------------------------------------------------------
module tb_cfg_frame_parser;

    logic        clk_sys;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        inter_cfg_wr_en;
    logic        inter_cfg_rd_en;
    logic [15:0] inter_cfg_addr;
    logic [31:0] inter_cfg_wr_data;
    logic [31:0] inter_cfg_rd_data;
    logic        inter_cfg_rd_data_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] frame_err_cnt;

    cfg_frame_parser #(
        .BYTE_TIMEOUT (32'd100)
    ) dut (
        .clk_sys                 (clk_sys),
        .rst_n                   (rst_n),
        .rx_data                 (rx_data),
        .rx_valid                (rx_valid),
        .inter_cfg_wr_en         (inter_cfg_wr_en),
        .inter_cfg_rd_en         (inter_cfg_rd_en),
        .inter_cfg_addr          (inter_cfg_addr),
        .inter_cfg_wr_data       (inter_cfg_wr_data),
        .inter_cfg_rd_data       (inter_cfg_rd_data),
        .inter_cfg_rd_data_valid (inter_cfg_rd_data_valid),
        .tx_data                 (tx_data),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .frame_err_cnt           (frame_err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] err_exp    = 16'h0000;
    logic [15:0] last_addr  = 16'h0000;
    logic [31:0] last_wdata = 32'h0000_0000;

    int          tx_mode    = 0;
    bit          rd_respond = 1'b1;
    int          rd_delay   = 1;
    logic [31:0] rd_value   = 32'h0000_0000;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, run did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic err_inc();
        if (err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
    endtask

    // Reference model: what one complete frame must cause
    task automatic model_frame(input logic [7:0] cmd, input logic [15:0] addr,
                               input logic [31:0] data, input bit bad_cs);
        logic [31:0] rdat;
        int          s;
        if (bad_cs) begin
            err_inc();
        end else if (cmd == 8'h01) begin
            exp_wr.push_back({addr, data});
            last_addr  = addr;
            last_wdata = data;
        end else if (cmd == 8'h02) begin
            exp_rd.push_back(addr);
            last_addr = addr;
            rdat = rd_respond ? rd_value : 32'h0000_0000;
            if (!rd_respond) err_inc();
            exp_tx.push_back(8'hEB);
            exp_tx.push_back(8'h90);
            exp_tx.push_back(8'h02);
            exp_tx.push_back(addr[15:8]);
            exp_tx.push_back(addr[7:0]);
            for (int k = 3; k >= 0; k--) exp_tx.push_back(rdat[k*8 +: 8]);
            s = 2 + int'(addr[15:8]) + int'(addr[7:0]);
            for (int k = 0; k < 4; k++) s = s + int'(rdat[k*8 +: 8]);
`ifdef CFG_FRAME_CHECKSUM_EN
            exp_tx.push_back(8'(s % 256));
`endif
        end else begin
            err_inc();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_sys); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk_sys); #1;
        end
    endtask

    // gap_idx/gap_len force one specific idle gap after byte gap_idx of the frame
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] data,
                              input bit bad_cs, input bit extra_eb, input bit use_model,
                              input int gap_max, input int gap_idx, input int gap_len);
        logic [7:0] b[$];
        int         gap;
        b.push_back(8'hEB);
        b.push_back(8'h90);
        b.push_back(cmd);
        b.push_back(addr[15:8]);
        b.push_back(addr[7:0]);
        for (int k = 3; k >= 0; k--) b.push_back(data[k*8 +: 8]);
`ifdef CFG_FRAME_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            for (int k = 2; k < 9; k++) cs = cs + b[k];
            if (bad_cs) cs = (cs == 8'h00) ? 8'h01 : 8'h00;
            b.push_back(cs);
        end
`endif
        if (use_model) model_frame(cmd, addr, data, bad_cs);
        if (extra_eb) send_byte(8'hEB, 0);
        for (int i = 0; i < b.size(); i++) begin
            gap = (i == gap_idx) ? gap_len : int'($urandom_range(gap_max, 0));
            send_byte(b[i], gap);
        end
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0) && (n < 3000)) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            $display("FAIL quiet_timeout: %0d expected events still outstanding, 0 required",
                     exp_wr.size() + exp_rd.size() + exp_tx.size());
            exp_wr.delete();
            exp_rd.delete();
            exp_tx.delete();
        end
        repeat (20) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic quiet_checks(input string tag);
        check({tag, "_err_cnt"}, 64'(frame_err_cnt), 64'(err_exp));
        check({tag, "_addr_hold"}, 64'(inter_cfg_addr), 64'(last_addr));
        check({tag, "_wdata_hold"}, 64'(inter_cfg_wr_data), 64'(last_wdata));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk_sys); #1;
        end
        exp_wr.delete();
        exp_rd.delete();
        exp_tx.delete();
        err_exp    = 16'h0000;
        last_addr  = 16'h0000;
        last_wdata = 32'h0000_0000;
        check("rst_wr_en", 64'(inter_cfg_wr_en), 64'd0);
        check("rst_rd_en", 64'(inter_cfg_rd_en), 64'd0);
        check("rst_addr", 64'(inter_cfg_addr), 64'd0);
        check("rst_wdata", 64'(inter_cfg_wr_data), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_err_cnt", 64'(frame_err_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_tx_start();
        int n;
        n = 0;
        while (!tx_valid && (n < 200)) begin
            @(posedge clk_sys); #1;
            n++;
        end
        check("tx_start", 64'(tx_valid), 64'd1);
    endtask

    // Downstream ready pattern
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_sys); #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(1, 0));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Register slave answering read strobes
    initial begin
        inter_cfg_rd_data_valid = 1'b0;
        inter_cfg_rd_data       = 32'h0000_0000;
        forever begin
            @(negedge clk_sys);
            if (rst_n && inter_cfg_rd_en && rd_respond) begin
                repeat (rd_delay) @(posedge clk_sys);
                #1;
                inter_cfg_rd_data_valid = 1'b1;
                inter_cfg_rd_data       = rd_value;
                @(posedge clk_sys); #1;
                inter_cfg_rd_data_valid = 1'b0;
                inter_cfg_rd_data       = $urandom;
            end
        end
    end

    // Monitor: pop and compare on every strobe and tx handshake
    initial begin
        forever begin
            @(negedge clk_sys);
            if (rst_n) begin
                if (inter_cfg_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        $display("FAIL wr_unexpected: strobe addr %0h data %0h, no strobe expected",
                                 inter_cfg_addr, inter_cfg_wr_data);
                    end else begin
                        check("wr_addr_data", 64'({inter_cfg_addr, inter_cfg_wr_data}), 64'(exp_wr.pop_front()));
                    end
                end
                if (inter_cfg_rd_en) begin
                    if (exp_rd.size() == 0) begin
                        n_checks++;
                        $display("FAIL rd_unexpected: strobe addr %0h, no strobe expected", inter_cfg_addr);
                    end else begin
                        check("rd_addr", 64'(inter_cfg_addr), 64'(exp_rd.pop_front()));
                    end
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: byte %0h, no byte expected", tx_data);
                    end else begin
                        check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [31:0] data;
        bit          bad;
        int          r;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        do_reset();

        // Reference write frame
        send_frame(8'h01, 16'h0010, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        wait_quiet();
        quiet_checks("wr_example");

        // Reference read frame, data one cycle after the strobe
        rd_respond = 1'b1; rd_delay = 1; rd_value = 32'h0000_0010;
        send_frame(8'h02, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        wait_quiet();
        quiet_checks("rd_example");

`ifdef CFG_FRAME_CHECKSUM_EN
        // Bad checksum on a write frame
        send_frame(8'h01, 16'h0010, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 0, -1, 0);
        wait_quiet();
        quiet_checks("bad_cs");
`endif

        // Resync on EB EB 90
        rd_delay = 3; rd_value = 32'hCAFE_F00D;
        send_frame(8'h02, 16'hA55A, 32'h1111_2222, 1'b0, 1'b1, 1'b1, 1, -1, 0);
        wait_quiet();
        quiet_checks("resync");

        // Read data never arrives, downstream ready toggling
        rd_respond = 1'b0; tx_mode = 1;
        send_frame(8'h02, 16'h0BAD, 32'h0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        wait_quiet();
        quiet_checks("rd_timeout");
        rd_respond = 1'b1; tx_mode = 0;

        // Byte timeout: 101 idle cycles after the 4th byte aborts the frame
        send_byte(8'hEB, 0);
        send_byte(8'h90, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 101);
        err_inc();
        wait_quiet();
        quiet_checks("byte_timeout");
        send_frame(8'h01, 16'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 2, -1, 0);
        wait_quiet();
        quiet_checks("after_timeout");

        // Exactly 100 idle cycles inside a frame is still allowed
        send_frame(8'h01, 16'h4321, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b1, 1, 4, 100);
        wait_quiet();
        quiet_checks("gap_limit");

        // Bytes arriving while the response is stalled are dropped
        rd_delay = 2; rd_value = 32'h5566_7788; tx_mode = 3;
        send_frame(8'h02, 16'h00F0, 32'h0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        wait_tx_start();
        send_frame(8'h01, 16'h7777, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        tx_mode = 0;
        wait_quiet();
        quiet_checks("drop_in_tx");

        // Reset mid-frame: the tail of the old frame must not execute
        send_byte(8'hEB, 0);
        send_byte(8'h90, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        wait_quiet();
        quiet_checks("rst_mid_frame");

        // Reset mid-response
        tx_mode = 3;
        send_frame(8'h02, 16'h0101, 32'h0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        wait_tx_start();
        do_reset();
        tx_mode = 0;
        repeat (5) begin
            @(posedge clk_sys); #1;
        end
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        send_frame(8'h01, 16'h0202, 32'h0303_0404, 1'b0, 1'b0, 1'b1, 1, -1, 0);
        wait_quiet();
        quiet_checks("after_rst_tx");

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(99, 0));
            if (r < 45) begin
                cmd = 8'h01;
            end else if (r < 85) begin
                cmd = 8'h02;
            end else begin
                cmd = 8'($urandom);
                if ((cmd == 8'h01) || (cmd == 8'h02)) cmd = 8'h55;
            end
            addr = 16'($urandom);
            data = $urandom;
            bad  = 1'b0;
`ifdef CFG_FRAME_CHECKSUM_EN
            bad  = ($urandom_range(99, 0) < 15);
`endif
            rd_respond = ($urandom_range(99, 0) < 85);
            rd_delay   = int'($urandom_range(10, 1));
            rd_value   = $urandom;
            tx_mode    = int'($urandom_range(2, 0));
            repeat ($urandom_range(2, 0)) begin
                r = int'($urandom_range(255, 0));
                if ((r == 'hEB) || (r == 'h90)) r = 'h00;
                send_byte(8'(r), 0);
            end
            send_frame(cmd, addr, data, bad, 1'($urandom_range(1, 0)), 1'b1, 3, -1, 0);
            wait_quiet();
            quiet_checks("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
